// File: rtl/mac_pkg.sv
// Shared instruction-bit positions, mode encodings and the psum saturation helpers
// used by the dual-mode MAC row and its tiles.
package mac_pkg;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_DRAIN = 2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Widest psum the helpers support; callers truncate the result to their own width.
  localparam int SAT_W = 32;

  function automatic logic signed [SAT_W:0] sat_hi(input int unsigned w);
    sat_hi = (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  function automatic logic signed [SAT_W:0] sat_lo(input int unsigned w);
    sat_lo = -sat_hi(w) - 33'sd1;
  endfunction

  function automatic logic [SAT_W-1:0] sat(input logic signed [SAT_W:0] x,
                                           input int unsigned w);
    logic signed [SAT_W:0] hi, lo;
    hi = sat_hi(w);
    lo = sat_lo(w);
    if (x > hi)      sat = hi[SAT_W-1:0];
    else if (x < lo) sat = lo[SAT_W-1:0];
    else             sat = x[SAT_W-1:0];
  endfunction

  function automatic logic clips(input logic signed [SAT_W:0] x, input int unsigned w);
    clips = (x > sat_hi(w)) || (x < sat_lo(w));
  endfunction

endpackage

// File: rtl/mac_tile_dm.sv
// One dual-mode MAC tile: weight/accumulator registers, saturating MAC, and the
// registered east-bound forwarding of activation, instruction and mode.
module mac_tile_dm
  import mac_pkg::*;
#(
  parameter int BW         = 4,
  parameter int PSUM_BW    = 16,
  parameter int ACT_SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BW-1:0]      in_w,
  input  logic [2:0]         inst_w,
  input  logic               mode_w,
  input  logic [PSUM_BW-1:0] in_n,
  output logic [BW-1:0]      out_e,
  output logic [2:0]         inst_e,
  output logic               mode_e,
  output logic [PSUM_BW-1:0] out_s,
  output logic               valid,
  output logic               ovf
);

  logic signed [BW:0]        a_ext;
  logic signed [BW-1:0]      b_q;
  logic signed [BW-1:0]      w_os;
  logic signed [PSUM_BW-1:0] acc_q;
  logic                      load_ready_q;
  logic signed [2*BW:0]      prod_ws, prod_os;
  logic signed [PSUM_BW:0]   sum_ws, sum_os;
  logic [PSUM_BW-1:0]        sat_ws, sat_os;
  logic                      clip_ws, clip_os;
  logic                      is_ws, do_exec, do_drain, take_load;

  assign a_ext   = (ACT_SIGNED != 0) ? {in_w[BW-1], in_w} : {1'b0, in_w};
  assign w_os    = in_n[BW-1:0];
  assign prod_ws = a_ext * b_q;
  assign prod_os = a_ext * w_os;

  assign sum_ws  = $signed({in_n[PSUM_BW-1], in_n}) + (PSUM_BW+1)'(prod_ws);
  assign sum_os  = $signed({acc_q[PSUM_BW-1], acc_q}) + (PSUM_BW+1)'(prod_os);

  assign sat_ws  = PSUM_BW'(sat((SAT_W+1)'(sum_ws), PSUM_BW));
  assign sat_os  = PSUM_BW'(sat((SAT_W+1)'(sum_os), PSUM_BW));
  assign clip_ws = clips((SAT_W+1)'(sum_ws), PSUM_BW);
  assign clip_os = clips((SAT_W+1)'(sum_os), PSUM_BW);

  assign is_ws     = (mode_w == MODE_WS);
  assign do_exec   = inst_w[INST_EXEC];
  assign do_drain  = inst_w[INST_DRAIN];
  // A load is claimed by the first still-empty tile; everyone east of it never sees it.
  assign take_load = is_ws && inst_w[INST_LOAD] && load_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_e        <= '0;
      inst_e       <= '0;
      mode_e       <= MODE_WS;
      out_s        <= '0;
      valid        <= 1'b0;
      ovf          <= 1'b0;
      b_q          <= '0;
      acc_q        <= '0;
      load_ready_q <= 1'b1;
    end else begin
      out_e  <= in_w;
      mode_e <= mode_w;
      inst_e <= {inst_w[INST_DRAIN], inst_w[INST_EXEC], inst_w[INST_LOAD] & ~take_load};
      valid  <= 1'b0;

      // Execute reads b_q before this edge, so a same-cycle load only affects later execs.
      if (take_load) begin
        b_q          <= in_w;
        load_ready_q <= 1'b0;
      end

      if (is_ws) begin
        if (do_exec) begin
          out_s <= sat_ws;
          valid <= 1'b1;
          if (clip_ws) ovf <= 1'b1;
        end
      end else begin
        if (do_exec) begin
          out_s <= {{(PSUM_BW-BW){1'b0}}, in_n[BW-1:0]};
          acc_q <= sat_os;
          if (clip_os) ovf <= 1'b1;
        end
        if (do_drain) begin
          out_s <= do_exec ? sat_os : acc_q;
          acc_q <= '0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_row_dm.sv
// Dual-mode (WS/OS) MAC row: a west-to-east chain of COL tiles sharing one
// instruction stream, each tile producing its own registered south output.
module mac_row_dm
  import mac_pkg::*;
#(
  parameter int BW         = 4,
  parameter int PSUM_BW    = 16,
  parameter int COL        = 8,
  parameter int ACT_SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BW-1:0]          in_w,
  input  logic [2:0]             inst_w,
  input  logic                   mode_w,
  input  logic [PSUM_BW*COL-1:0] in_n,
  output logic [PSUM_BW*COL-1:0] out_s,
  output logic [COL-1:0]         valid,
  output logic [COL-1:0]         ovf
);

  logic [BW-1:0] a_chain    [COL+1];
  logic [2:0]    inst_chain [COL+1];
  logic          mode_chain [COL+1];
  logic          unused_east;

  assign a_chain[0]    = in_w;
  assign inst_chain[0] = inst_w;
  assign mode_chain[0] = mode_w;

  for (genvar i = 0; i < COL; i++) begin : g_tile
    mac_tile_dm #(
      .BW        (BW),
      .PSUM_BW   (PSUM_BW),
      .ACT_SIGNED(ACT_SIGNED)
    ) u_tile (
      .clk   (clk),
      .rst   (reset),
      .in_w  (a_chain[i]),
      .inst_w(inst_chain[i]),
      .mode_w(mode_chain[i]),
      .in_n  (in_n[i*PSUM_BW +: PSUM_BW]),
      .out_e (a_chain[i+1]),
      .inst_e(inst_chain[i+1]),
      .mode_e(mode_chain[i+1]),
      .out_s (out_s[i*PSUM_BW +: PSUM_BW]),
      .valid (valid[i]),
      .ovf   (ovf[i])
    );
  end

  // The east edge of the last tile has no consumer in this row.
  assign unused_east = ^{a_chain[COL], inst_chain[COL], mode_chain[COL]};

endmodule

// File: tb/tb_mac_row_dm.sv
// Scoreboard bench for mac_row_dm: an unsigned-activation and a signed-activation row
// run the same stimulus against a transaction-level model of both.
module tb_mac_row_dm;

  localparam int BW = 4;
  localparam int PB = 16;
  localparam int COL = 8;
  localparam int MAXS = 72;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [BW-1:0] in_w = '0;
  logic [2:0] inst_w = '0;
  logic mode_w = 1'b0;
  logic [PB*COL-1:0] in_n = '0;
  logic [PB*COL-1:0] out_s0, out_s1;
  logic [COL-1:0] valid0, valid1, ovf0, ovf1;

  always #5 clk = ~clk;

  mac_row_dm #(.BW(BW), .PSUM_BW(PB), .COL(COL), .ACT_SIGNED(0)) dut_u (
    .clk(clk), .reset(rst), .in_w(in_w), .inst_w(inst_w), .mode_w(mode_w),
    .in_n(in_n), .out_s(out_s0), .valid(valid0), .ovf(ovf0));

  mac_row_dm #(.BW(BW), .PSUM_BW(PB), .COL(COL), .ACT_SIGNED(1)) dut_s (
    .clk(clk), .reset(rst), .in_w(in_w), .inst_w(inst_w), .mode_w(mode_w),
    .in_n(in_n), .out_s(out_s1), .valid(valid1), .ovf(ovf1));

  logic [2:0]    st_inst [MAXS];
  logic          st_mode [MAXS];
  logic [BW-1:0] st_w    [MAXS];
  logic [PB-1:0] st_n    [MAXS][COL];

  int             exp_q  [2][COL][$];
  logic [COL-1:0] exp_v  [2][MAXS];
  logic [COL-1:0] exp_ovf[2];

  int    checks = 0;
  int    errors = 0;
  int    slot = 0;
  bit    mon_en = 1'b0;
  string cur_name = "";

  function automatic int sx(input logic [15:0] v, input int w);
    int u;
    u = int'(v) & ((1 << w) - 1);
    return (u >= (1 << (w - 1))) ? u - (1 << w) : u;
  endfunction

  function automatic int clamp(input int x, output bit clip);
    clip = 1'b0;
    if (x > 32767)  begin clip = 1'b1; return 32767;  end
    if (x < -32768) begin clip = 1'b1; return -32768; end
    return x;
  endfunction

  function automatic int col_val(input logic [PB*COL-1:0] v, input int i);
    logic [PB-1:0] t;
    t = v[i*PB +: PB];
    return sx(t, PB);
  endfunction

  // Transaction view: the instruction issued at cycle c reaches column i at cycle c+i,
  // sees that cycle's in_n, and shows up on the south port one cycle later.
  // The k-th WS load since reset is claimed by column k.
  task automatic build_model(input int d);
    int  b[COL];
    int  acc[COL];
    int  tgt[MAXS];
    int  lc, av, nv, t, so;
    bit  clip;
    lc = 0;
    exp_ovf[d] = '0;
    for (int i = 0; i < COL; i++) begin
      b[i] = 0;
      acc[i] = 0;
      exp_q[d][i].delete();
    end
    for (int s = 0; s < MAXS; s++) exp_v[d][s] = '0;
    for (int c = 0; c < MAXS; c++) begin
      tgt[c] = -1;
      if (!st_mode[c] && st_inst[c][0]) begin
        if (lc < COL) tgt[c] = lc;
        lc++;
      end
    end
    for (int c = 0; c < MAXS; c++) begin
      for (int i = 0; i < COL; i++) begin
        so = c + 1 + i;
        if (st_inst[c] == 3'b000 || so >= MAXS) continue;
        av = (d == 1) ? sx(16'(st_w[c]), BW) : int'(st_w[c]);
        nv = sx(st_n[c+i][i], PB);
        if (!st_mode[c]) begin
          if (st_inst[c][1]) begin
            t = clamp(nv + av * b[i], clip);
            if (clip) exp_ovf[d][i] = 1'b1;
            exp_q[d][i].push_back(t);
            exp_v[d][so][i] = 1'b1;
          end
          if (tgt[c] == i) b[i] = sx(16'(st_w[c]), BW);
        end else begin
          if (st_inst[c][1]) begin
            acc[i] = clamp(acc[i] + av * sx(16'(st_n[c+i][i][BW-1:0]), BW), clip);
            if (clip) exp_ovf[d][i] = 1'b1;
          end
          if (st_inst[c][2]) begin
            exp_q[d][i].push_back(acc[i]);
            exp_v[d][so][i] = 1'b1;
            acc[i] = 0;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [COL-1:0] vld;
        int got, want;
        vld = (d == 0) ? valid0 : valid1;
        checks++;
        if (vld !== exp_v[d][slot]) begin
          errors++;
          $display("FAIL %s valid dut%0d slot %0d got %b want %b", cur_name, d, slot, vld, exp_v[d][slot]);
        end
        for (int i = 0; i < COL; i++) begin
          if (vld[i] === 1'b1) begin
            got = col_val((d == 0) ? out_s0 : out_s1, i);
            checks++;
            if (exp_q[d][i].size() == 0) begin
              errors++;
              $display("FAIL %s unexpected out dut%0d col %0d got %0d want none", cur_name, d, i, got);
            end else begin
              want = exp_q[d][i].pop_front();
              if (got != want) begin
                errors++;
                $display("FAIL %s out_s dut%0d col %0d got %0d want %0d", cur_name, d, i, got, want);
              end
            end
          end
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if (out_s0 !== '0 || valid0 !== '0 || ovf0 !== '0 ||
        out_s1 !== '0 || valid1 !== '0 || ovf1 !== '0) begin
      errors++;
      $display("FAIL %s reset state got out %h/%h valid %b/%b ovf %b/%b want all 0",
               nm, out_s0, out_s1, valid0, valid1, ovf0, ovf1);
    end
  endtask

  task automatic clear_stim();
    for (int s = 0; s < MAXS; s++) begin
      st_inst[s] = '0;
      st_mode[s] = 1'b0;
      st_w[s] = '0;
      for (int i = 0; i < COL; i++) st_n[s][i] = '0;
    end
  endtask

  task automatic apply(input int s);
    in_w = st_w[s];
    inst_w = st_inst[s];
    mode_w = st_mode[s];
    for (int i = 0; i < COL; i++) in_n[i*PB +: PB] = st_n[s][i];
  endtask

  task automatic run(input string nm, input int abort_at, input bit do_reset);
    cur_name = nm;
    build_model(0);
    build_model(1);
    inst_w = '0;
    in_w = '0;
    mode_w = 1'b0;
    in_n = '0;
    if (do_reset) begin
      @(negedge clk);
      rst = 1'b1;
      #2;
      check_zero({nm, "_rst"});
      @(negedge clk);
      rst = 1'b0;
    end
    for (int s = 0; s < MAXS; s++) begin
      @(posedge clk);
      #1;
      apply(s);
      slot = s;
      mon_en = 1'b1;
      if (s == abort_at) begin
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_zero({nm, "_midreset"});
        @(negedge clk);
        rst = 1'b0;
        inst_w = '0;
        return;
      end
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (((d == 0) ? ovf0 : ovf1) !== exp_ovf[d]) begin
        errors++;
        $display("FAIL %s ovf dut%0d got %b want %b", nm, d, (d == 0) ? ovf0 : ovf1, exp_ovf[d]);
      end
      for (int i = 0; i < COL; i++) begin
        checks++;
        if (exp_q[d][i].size() != 0) begin
          errors++;
          $display("FAIL %s missing outputs dut%0d col %0d got 0 want %0d more",
                   nm, d, i, exp_q[d][i].size());
        end
      end
    end
  endtask

  function automatic logic [PB-1:0] rand_n();
    case ($urandom_range(0, 3))
      0:       return 16'(32767 - $urandom_range(0, 100));
      1:       return 16'(32768 + $urandom_range(0, 100));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Reset in the middle of a WS load/execute stream, then a fresh load sequence.
    clear_stim();
    for (int c = 0; c < 8; c++) begin
      st_inst[c] = (c < 4) ? 3'b001 : 3'b010;
      st_w[c] = 4'(c + 3);
    end
    run("midreset", 5, 1'b1);

    clear_stim();
    for (int c = 0; c < 8; c++) begin
      st_inst[c] = 3'b001;
      st_w[c] = 4'(c + 1);
    end
    st_inst[8] = 3'b010;
    st_w[8] = 4'd2;
    run("ws_load", -1, 1'b0);

    clear_stim();
    st_inst[0] = 3'b001; st_w[0] = 4'd7;
    st_inst[1] = 3'b010; st_w[1] = 4'd7;
    for (int s = 0; s < MAXS; s++) st_n[s][0] = 16'd32767;
    run("ws_sat", -1, 1'b1);

    clear_stim();
    for (int c = 0; c < 6; c++) begin
      st_mode[c] = 1'b1;
      st_inst[c] = (c < 4) ? 3'b010 : 3'b100;
      st_w[c] = 4'd3;
    end
    for (int s = 0; s < MAXS; s++)
      for (int i = 0; i < COL; i++) st_n[s][i] = 16'h000E;
    run("os_drain", -1, 1'b1);

    clear_stim();
    st_inst[0] = 3'b001; st_w[0] = 4'd3;
    st_inst[1] = 3'b010; st_w[1] = 4'hF;
    run("act_sign", -1, 1'b1);

    clear_stim();
    for (int c = 0; c < 8; c++) begin
      st_inst[c] = 3'b001;
      st_w[c] = 4'($urandom);
    end
    st_inst[8]  = 3'b010; st_mode[8]  = 1'b0; st_w[8]  = 4'($urandom);
    st_inst[9]  = 3'b010; st_mode[9]  = 1'b1; st_w[9]  = 4'($urandom);
    st_inst[10] = 3'b011; st_mode[10] = 1'b0; st_w[10] = 4'($urandom);
    st_inst[11] = 3'b110; st_mode[11] = 1'b1; st_w[11] = 4'($urandom);
    st_inst[12] = 3'b010; st_mode[12] = 1'b0; st_w[12] = 4'($urandom);
    st_inst[13] = 3'b100; st_mode[13] = 1'b1;
    for (int s = 0; s < MAXS; s++)
      for (int i = 0; i < COL; i++) st_n[s][i] = 16'($urandom_range(0, 2000));
    run("mixed", -1, 1'b1);

    for (int r = 0; r < 5; r++) begin
      clear_stim();
      for (int c = 0; c < MAXS - COL - 4; c++) begin
        st_inst[c] = 3'($urandom);
        st_mode[c] = 1'($urandom);
        st_w[c] = 4'($urandom);
      end
      for (int s = 0; s < MAXS; s++)
        for (int i = 0; i < COL; i++) st_n[s][i] = rand_n();
      run($sformatf("random%0d", r), -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
